// File: rtl/mem_pkg.sv
// Shared encodings for the byte-lane data memory: access sizes and clear-engine states.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } clr_state_t;

endpackage

// File: rtl/mem_load_align.sv
// Load-path aligner: picks the addressed byte or halfword out of a memory word
// and sign- or zero-extends it; word loads pass through untouched.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[8*i_lane +: 8];
    assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data = i_word;
        case (i_size)
            SZ_B:    o_data = {{24{w_byte[7] & ~i_uns}}, w_byte};
            SZ_H:    o_data = {{16{w_half[15] & ~i_uns}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/data_mem_bytelane.sv
// Data memory for the single-cycle MIPS datapath: byte/half/word stores via lane
// enables, extended loads, fault detection, sticky error, and a post-reset clear sweep.
module data_mem_bytelane
    import mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int TST_IDX = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic        i_re,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd,
    output logic        o_fault,
    output logic        o_err,
    output logic        o_busy,
    output logic [31:0] o_tst
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

    logic [31:0]   r_mem [DEPTH];
    clr_state_t    r_state;
    clr_state_t    w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_ptr_nxt;
    logic          r_err;

    logic [AW-1:0] w_wi;
    logic          w_oor;
    logic          w_fault;
    logic          w_busy;
    logic          w_store;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_ldata;

    assign w_wi   = i_addr[AW+1:2];
    assign w_oor  = {1'b0, i_addr} >= LIMIT;
    assign w_busy = (r_state == ST_CLEAR);

    assign w_fault = (i_we | i_re) &
                     ((i_size == SZ_X) |
                      ((i_size == SZ_H) & i_addr[0]) |
                      ((i_size == SZ_W) & (i_addr[1:0] != 2'b00)) |
                      w_oor);

    assign w_store = i_we & ~w_fault & ~w_busy;

    // Store data is replicated across lanes so each enabled lane just takes its own slice.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = i_wd;
        case (i_size)
            SZ_B: begin
                w_be[i_addr[1:0]] = 1'b1;
                w_wdata           = {4{i_wd[7:0]}};
            end
            SZ_H: begin
                w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_wd[15:0]}};
            end
            SZ_W:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // The array has no reset; the clear engine owns the write port until READY.
    always_ff @(posedge clk) begin
        if (rst && (r_state == ST_CLEAR)) begin
            r_mem[r_ptr] <= '0;
        end else if (w_store) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_wi][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_CLEAR: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == AW'(DEPTH - 1)) begin
                    w_state_nxt = ST_READY;
                end
            end
            default: w_state_nxt = ST_READY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_fault && !w_busy) begin
                r_err <= 1'b1;
            end
        end
    end

    mem_load_align u_align (
        .i_word (r_mem[w_wi]),
        .i_lane (i_addr[1:0]),
        .i_size (i_size),
        .i_uns  (i_uns),
        .o_data (w_ldata)
    );

    assign o_rd    = (w_fault | w_busy) ? 32'h0 : w_ldata;
    assign o_fault = w_fault;
    assign o_err   = r_err;
    assign o_busy  = w_busy;
    assign o_tst   = r_mem[TST_IDX];

endmodule

// File: doc/data_mem_bytelane.md
# data_mem_bytelane

Parametrised data memory for the single-cycle MIPS datapath. It supports byte, halfword and word stores through per-byte lane enables, and byte, halfword and word loads with sign or zero extension. Misaligned and out-of-range accesses are detected, flagged and suppressed. After reset, a sequential clear engine zeroes the array one word per cycle while `busy` is asserted.

## Interface
Parameters:
- `DEPTH`, 256: number of 32-bit words; power of two, at least 4.
- `TST_IDX`, 0: word index mirrored on `tst`.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `we`, in, 1: store request.
- `re`, in, 1: load request; only qualifies error detection.
- `size`, in, 2: access size; 00 byte, 01 half, 10 word, 11 illegal.
- `uns`, in, 1: zero-extend loads when 1, sign-extend when 0.
- `addr`, in, 32: byte address.
- `wd`, in, 32: store data, right-justified.
- `rd`, out, 32: load data, combinational.
- `fault`, out, 1: combinational error for the current access.
- `err`, out, 1: sticky registered error flag.
- `busy`, out, 1: clear engine active.
- `tst`, out, 32: contents of word `TST_IDX`.

## Operation
- Word index: `wi = addr[log2(DEPTH)+1:2]`. Byte lane: `k = addr[1:0]`. Little-endian; lane `k` is bits `8k+7:8k`.
- `fault` = (`we` | `re`) & (`size`==11 | (`size`==01 & `addr[0]`) | (`size`==10 & `addr[1:0]`≠0) | `addr` ≥ 4·DEPTH).
- Store (`we` & !`fault` & !`busy`):
  - Byte: `wd[7:0]` goes to lane `k`.
  - Half: `wd[15:0]` goes to lanes `{2·addr[1]+1, 2·addr[1]}`.
  - Word: all lanes.
  - Untouched lanes keep their value.
- Load:
  - Byte: lane `k`.
  - Half: lanes selected by `addr[1]`.
  - Byte and half results are extended to 32 bits per `uns`.
  - Word: returned unmodified.
  - `rd` = 0 when `fault` or `busy`.
- `err`: set on any rising edge where `fault` = 1 and `busy` = 0. Cleared only by `rst`.
- `tst` = raw word `TST_IDX`. It reads 0 during clear only because the array is being zeroed.
- Clear FSM has two states:
  - CLEAR: write 0 to word `ptr`, then `ptr++`. Go to READY after writing word DEPTH-1.
  - READY: terminal state.

## Timing
- Reset values (async): state = CLEAR, `ptr` = 0, `busy` = 1, `err` = 0, `fault` = 0 while `we` = `re` = 0, `rd` = 0. Array contents are undefined until the clear completes.
- Clear engine:
  - First zeroing write happens at the first rising edge after `rst` deasserts.
  - Word DEPTH-1 is written at edge DEPTH.
  - `busy` falls after edge DEPTH; the first accepted store is at edge DEPTH+1.
- Store latency: commits at the rising edge; `rd` reflects it after that edge. A same-cycle load before the edge returns the old data.
- `we` with `fault` or `busy`: no array change. Repeated faults leave `err` at 1.
- `rst` asserted mid-clear or mid-operation: immediately returns to CLEAR with `ptr` = 0 and restarts the full sweep.
- `ptr` is log2(DEPTH) bits. Leaving CLEAR is decided on `ptr` == DEPTH-1, not on wrap-around.

## Structure
- Package `mem_pkg` holds:
  - size encodings `SZ_B`, `SZ_H`, `SZ_W`;
  - the clear FSM state typedef (`ST_CLEAR`, `ST_READY`).
- Sub-module `mem_load_align` (combinational) takes word, `addr[1:0]`, `size`, `uns` and produces the extended load value.
- The top level holds the array, lane-enable generation, fault logic, the FSM and `err`.

## Test plan
- Reset release, DEPTH = 16: `busy` = 1 for exactly 16 edges. Afterwards every word reads 0, `err` = 0, and a store attempted during `busy` is dropped.
- SW 0x11223344 @0x8, then SB 0xAA @0x9: LW @0x8 = 0x1122AA44. LBU @0x9 = 0x000000AA. LB @0x9 = 0xFFFFFFAA.
- SH 0x8001 @0xA onto 0x00000000: LW = 0x80010000. LH @0xA = 0xFFFF8001. LHU @0xA = 0x00008001.
- Faulting accesses:
  - LW @0x6, SH @0x3, and `size` = 11 each give `fault` = 1, `rd` = 0 and no array change.
  - `err` rises at the next edge and holds through subsequent legal accesses.
- Store @4·DEPTH gives a fault with no aliasing: word 0 is unchanged. Store to `TST_IDX`·4 appears on `tst` after the edge.
- Assert `rst` at clear cycle 5, then at a mid-operation store: `busy` re-asserts, `err` clears, and the sweep restarts with a full DEPTH-cycle `busy` window.
